// File: rtl/da_fir_serial_if.sv
// Sample/coefficient/result bundle for the bit-serial distributed-arithmetic FIR.
// The slave side is the filter; the master side is the sample source and update engine.
interface da_fir_serial_if #(
  parameter int XW   = 8,
  parameter int CW   = 10,
  parameter int NGRP = 1
);
  localparam int N  = 4 * NGRP;
  localparam int AW = $clog2(N);
  localparam int YW = CW + XW + 2 + $clog2(NGRP);

  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [XW-1:0]        x_in;
  logic                 out_valid;
  logic signed [YW-1:0] y_out;
  logic                 busy;

  modport slave (
    input  coef_we, coef_addr, coef_data, in_valid, x_in,
    output in_ready, out_valid, y_out, busy
  );

  modport master (
    output coef_we, coef_addr, coef_data, in_valid, x_in,
    input  in_ready, out_valid, y_out, busy
  );
endinterface

// File: rtl/da_fir_serial.sv
// Bit-serial distributed-arithmetic FIR: one sample bit per cycle, LSB first,
// with per-group 16-entry partial-sum tables built from loadable coefficients.
module da_fir_serial #(
  parameter int XW       = 8,
  parameter int CW       = 10,
  parameter int NGRP     = 1,
  parameter int SIGNED_X = 1
) (
  input logic            clk,
  input logic            r,
  da_fir_serial_if.slave bus
);
  localparam int N    = 4 * NGRP;
  localparam int AW   = $clog2(N);
  localparam int SW   = CW + 2 + $clog2(NGRP);
  localparam int YW   = CW + XW + 2 + $clog2(NGRP);
  localparam int CNTW = (XW > 1) ? $clog2(XW) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(XW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic [CNTW-1:0]      cnt_q;
  logic signed [YW-1:0] acc_q;
  logic signed [YW-1:0] acc_d;
  logic signed [YW-1:0] y_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 out_valid_q;
  logic [XW-1:0]        tap_q  [N];
  logic signed [CW-1:0] coef_q [N];

  logic signed [CW+1:0] grp_sum [NGRP];
  logic signed [SW-1:0] s_k;
  logic signed [YW-1:0] term;
  logic                 accept;
  logic                 coef_ok;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    logic signed [CW+1:0] lut [16];
    logic [3:0]           addr;

    // Entry e holds the sum of the coefficients whose bit is set in e.
    always_comb begin
      for (int e = 0; e < 16; e++) begin
        lut[e] = '0;
        for (int b = 0; b < 4; b++) begin
          if (e[b]) lut[e] = lut[e] + coef_q[4*gi+b];
        end
      end
    end

    assign addr = {tap_q[4*gi+3][cnt_q], tap_q[4*gi+2][cnt_q],
                   tap_q[4*gi+1][cnt_q], tap_q[4*gi][cnt_q]};
    assign grp_sum[gi] = lut[addr];
  end

  always_comb begin
    s_k = '0;
    for (int g = 0; g < NGRP; g++) s_k = s_k + SW'(grp_sum[g]);
  end

  // The sign bit of a two's-complement sample carries negative weight:
  // subtract by adding the inverted term with a carry-in of one.
  always_comb begin
    term = YW'(s_k) <<< cnt_q;
    if (SIGNED_X != 0 && cnt_q == LAST) acc_d = acc_q + ~term + YW'(1);
    else                                acc_d = acc_q + term;
  end

  assign accept  = in_ready_q & bus.in_valid;
  assign coef_ok = (state_q != RUN) && bus.coef_we && (int'(bus.coef_addr) < N);

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        tap_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (coef_ok) coef_q[bus.coef_addr] <= bus.coef_data;

      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            tap_q[0] <= bus.x_in;
            for (int i = 1; i < N; i++) tap_q[i] <= tap_q[i-1];
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            y_q         <= acc_d;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y_out     = y_q;
endmodule

// File: doc/da_fir_serial.md
Name: da_fir_serial

Overview:
- Parametrised bit-serial distributed-arithmetic FIR filter; successor to the fixed 4-tap, 8-bit DA block.
- Taps are grouped in fours; each group forms a 16-entry partial-sum lookup from runtime-loadable coefficients.
- The block owns its sample delay line, bit counter, MSB sign correction and valid/ready handshake, so no external bit-select sequencing is needed.
- Sits between the sample source and the adaptive update logic; coefficients are rewritten by the update engine between samples.

Parameters:
- XW, 8: sample width in bits; also the number of serial cycles per output.
- CW, 10: coefficient width, signed two's complement.
- NGRP, 1: number of 4-tap groups; tap count N = 4*NGRP.
- SIGNED_X, 1: 1 = samples are two's complement (MSB weight negative); 0 = samples are unsigned.

Ports:
- clk  in  1  clock, rising edge.
- r  in  1  reset, asynchronous, active-low.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(N)  tap index to write (0 = newest-sample tap).
- coef_data  in  CW  signed coefficient value.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- x_in  in  XW  sample.
- out_valid  out  1  one-cycle pulse; y_out is new.
- y_out  out  YW  filter result, signed; YW = CW+XW+2+clog2(NGRP) (clog2(1)=0).
- busy  out  1  high in RUN.

Behaviour:
- Reset (r low, asynchronous):
  - state=IDLE; bit counter=0; accumulator=0.
  - All N delay-line registers and all N coefficient registers = 0.
  - y_out=0, out_valid=0, in_ready=1, busy=0.
- States:
  - IDLE: in_ready=1. Accept (in_valid & in_ready) -> RUN.
  - RUN: busy=1, in_ready=0. One bit per cycle, k = 0..XW-1, LSB first. After k=XW-1 -> DONE.
  - DONE: out_valid=1 for this cycle only; y_out updated on entry and held until the next DONE; in_ready=1.
  - From DONE: accept -> RUN (back-to-back operation); otherwise -> IDLE.
- Accept edge actions:
  - Delay line shifts: tap0 <= x_in, tap(i) <= tap(i-1).
  - Accumulator cleared; counter = 0.
- Timing:
  - Accept at edge E0 gives out_valid high in the cycle after edge E0+XW.
  - Latency XW+1 cycles; maximum throughput one sample per XW+1 cycles.
- Per RUN cycle k:
  - Group g address = {tap(4g+3)[k], tap(4g+2)[k], tap(4g+1)[k], tap(4g)[k]}.
  - Lookup value = signed sum of that group's coefficients whose address bit is 1 (address 0 -> 0).
  - S_k = sum over all groups.
- Result:
  - y = sum_{k=0..XW-2} 2^k*S_k + w*2^(XW-1)*S_{XW-1}.
  - w = -1 if SIGNED_X=1 (negation done as invert plus carry-in, no separate subtractor); w = +1 if SIGNED_X=0.
  - Result is exact, with no saturation or truncation; YW guarantees no overflow for any input.
- Coefficient writes:
  - Honoured in IDLE and DONE; take effect from the next accepted sample.
  - coef_we in RUN is silently dropped (no effect, no flag).
  - coef_addr >= N is ignored.
- Simultaneous accept and coefficient write in IDLE/DONE: the write lands, and the sample just accepted uses the new coefficient.
- in_valid while in_ready=0: not accepted; the source must hold the sample.
- x_in is sampled only on the accept edge.
- Reset asserted mid-RUN: the computation is aborted, no out_valid pulse, and full reset values apply.

Test Plan:
- Reset -> y_out=0, out_valid=0, in_ready=1, busy=0; a push of x=5 with all coefficients still 0 gives y_out=0.
- NGRP=1, SIGNED_X=1, h=[1,2,3,4]; push samples 1,0,0,0,0 -> y_out sequence 1,2,3,4,0, one out_valid per sample.
- All h=-512, push x=-128 four times -> fourth y_out = +262144 (0x40000 in 20 bits, no overflow). Then push x=127 -> y_out = -512*(127-384) = +131584.
- in_valid held high continuously -> accepts exactly every 9 cycles. out_valid high for exactly one cycle, 9 cycles after each accept edge; busy high for exactly 8 cycles.
- coef_we (addr 0, data 7) during RUN -> current and next results unchanged. The same write in IDLE -> next impulse gives y_out=7.
- SIGNED_X=0, h0=1, push x=255 -> y_out=255. Reset pulsed at RUN cycle k=4 -> no out_valid, in_ready=1 after release, y_out=0.
